prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Write-side counterpart of the instruction fetch path (5-bit address counter + 32x16 instruction memory feeding the processor).
- Accepts a stream of 16-bit instruction words from a host over a valid/ready handshake.
- Issues one single-cycle write per word into the instruction memory's write port (address, data, wren).
- Reports completion, word count, a running checksum and overflow, so the program image can be loaded before the processor is released with run.

Parameters:
DATA_W, 16, instruction word width
ADDR_W, 5, memory address width
DEPTH, 32, number of memory words (must equal 2**ADDR_W)

Ports:
clock  input  1  single system clock, all state on rising edge
resetN  input  1  asynchronous, active-high reset (despite the N suffix, asserted = 1)
start  input  1  begin a new load; sampled only in IDLE, DONE, ERR
in_valid  input  1  host word valid
in_data  input  DATA_W  host instruction word
in_last  input  1  qualifies final word of the image, meaningful only with in_valid
in_ready  output  1  loader can accept a word this cycle
mem_addr  output  ADDR_W  memory write address, registered
mem_data  output  DATA_W  memory write data, registered
mem_wren  output  1  memory write enable, one-cycle pulse per word
busy  output  1  high in LOAD
loaded  output  1  image complete, high in DONE
overflow  output  1  image exceeded DEPTH words, high in ERR
word_count  output  ADDR_W+1  words written in current/last load (0..DEPTH)
checksum  output  DATA_W  sum of accepted words, modulo 2**DATA_W

Behaviour:
- Reset (async, any state): state=IDLE; in_ready=0, mem_addr=0, mem_data=0, mem_wren=0, busy=0, loaded=0, overflow=0, word_count=0, checksum=0; internal write pointer=0.
- States: IDLE, LOAD, DONE, ERR.
- IDLE: in_ready=0. start=1 -> LOAD next cycle; pointer, word_count, checksum cleared on the same edge.
- LOAD:
  - busy=1, in_ready=1 combinationally from state.
  - Accept = in_valid & in_ready.
  - On accept, at the clock edge: mem_addr<=pointer, mem_data<=in_data, mem_wren<=1, pointer+1, word_count+1, checksum<=checksum+in_data (carry discarded).
  - Write pulse therefore appears the cycle after accept; latency 1.
  - Back-to-back accepts give back-to-back wren pulses at consecutive addresses.
  - Cycles without accept: mem_wren=0; mem_addr/mem_data hold last value.
- LOAD transitions, evaluated on accept:
  - in_last=1 -> DONE. Word is written; the final mem_wren pulse occurs in the first DONE cycle.
  - in_last=0 with pointer=DEPTH-1 -> ERR. Word is written; pointer wraps to 0, not reused.
  - in_last=1 with pointer=DEPTH-1 -> DONE (exactly full image is legal; word_count=DEPTH).
- start in LOAD: ignored.
- DONE: loaded=1, in_ready=0, busy=0. Outputs word_count and checksum hold. start=1 -> LOAD with counters cleared and loaded dropping on the same edge.
- ERR: overflow=1 (sticky), in_ready=0. word_count=DEPTH; checksum covers all DEPTH accepted words. start=1 -> LOAD with overflow cleared.
- in_valid outside LOAD: never accepted, no write, no counter change.
- resetN mid-LOAD: immediate return to IDLE. Any pending mem_wren is deasserted asynchronously; partial image left in memory, loaded=0.
- Exactly one of busy/loaded/overflow is high in LOAD/DONE/ERR respectively; all low in IDLE.

Test Plan:
- Reset then start, 3 words 0x1234, 0x0001, 0xFFFF (last on third), in_valid held -> wren pulses at addr 0,1,2 with matching data on 3 consecutive cycles; loaded=1; word_count=3; checksum=0x1234.
- Host throttles in_valid (1 on, 2 off) for 4 words -> exactly 4 wren pulses, addresses 0..3, no wren in idle gaps; data unchanged between pulses.
- 32 words, in_last on word 32 -> DONE, word_count=32, overflow=0, last write addr 31.
- 33 words offered, no in_last -> ERR after word 32; overflow=1; in_ready=0; 33rd word not accepted; no write beyond addr 31.
- Assert resetN during word 5 of a load -> same-cycle mem_wren=0, all outputs to reset values; subsequent start reloads from addr 0.
- From DONE, start, load 1 word 0x00AA with in_last -> loaded drops then rises; word_count=1; checksum=0x00AA; write at addr 0.

Source files
------------

// File: rtl/prog_loader.sv
// Instruction-memory loader: takes a host word stream over valid/ready and issues one
// registered write per word into a DEPTH-entry memory, tracking count, checksum and overflow.
module prog_loader #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic                clock,
    input  logic                resetN,
    input  logic                start,
    input  logic                in_valid,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                in_last,
    output logic                in_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_data,
    output logic                mem_wren,
    output logic                busy,
    output logic                loaded,
    output logic                overflow,
    output logic [ADDR_W:0]     word_count,
    output logic [DATA_W-1:0]   checksum,
    output logic [1:0]          state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_data_q, mem_data_d;
    logic                mem_wren_q, mem_wren_d;
    logic [ADDR_W:0]     word_count_q, word_count_d;
    logic [DATA_W-1:0]   checksum_q, checksum_d;
    logic                busy_q, busy_d;
    logic                loaded_q, loaded_d;
    logic                overflow_q, overflow_d;
    logic                accept;

    // Handshake: a word transfers on any rising edge where in_valid and in_ready are both
    // high; in_ready is high exactly while loading and does not depend on in_valid.
    assign in_ready = (state_q == S_LOAD);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        mem_wren_d   = 1'b0;
        word_count_d = word_count_q;
        checksum_d   = checksum_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d      = S_LOAD;
                    ptr_d        = '0;
                    word_count_d = '0;
                    checksum_d   = '0;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    mem_addr_d   = ptr_q;
                    mem_data_d   = in_data;
                    mem_wren_d   = 1'b1;
                    ptr_d        = ptr_q + ADDR_W'(1);
                    word_count_d = word_count_q + (ADDR_W+1)'(1);
                    checksum_d   = checksum_q + in_data;
                    // A final word in the last slot is a legal full image, so in_last wins.
                    if (in_last) begin
                        state_d = S_DONE;
                    end else if (ptr_q == ADDR_W'(DEPTH-1)) begin
                        state_d = S_ERR;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d     = (state_d == S_LOAD);
        loaded_d   = (state_d == S_DONE);
        overflow_d = (state_d == S_ERR);
    end

    always_ff @(posedge clock or posedge resetN) begin
        if (resetN) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            mem_wren_q   <= 1'b0;
            word_count_q <= '0;
            checksum_q   <= '0;
            busy_q       <= 1'b0;
            loaded_q     <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            mem_wren_q   <= mem_wren_d;
            word_count_q <= word_count_d;
            checksum_q   <= checksum_d;
            busy_q       <= busy_d;
            loaded_q     <= loaded_d;
            overflow_q   <= overflow_d;
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_data   = mem_data_q;
    assign mem_wren   = mem_wren_q;
    assign busy       = busy_q;
    assign loaded     = loaded_q;
    assign overflow   = overflow_q;
    assign word_count = word_count_q;
    assign checksum   = checksum_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed image loads plus random streams,
// compared every cycle against a word-counting model and an expected-write queue.
module tb_prog_loader;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;
    localparam int WW     = ADDR_W + DATA_W;

    logic               clock = 1'b0;
    logic               resetN = 1'b1;
    logic               start = 1'b0;
    logic               in_valid = 1'b0;
    logic [DATA_W-1:0]  in_data = '0;
    logic               in_last = 1'b0;
    logic               in_ready;
    logic [ADDR_W-1:0]  mem_addr;
    logic [DATA_W-1:0]  mem_data;
    logic               mem_wren;
    logic               busy;
    logic               loaded;
    logic               overflow;
    logic [ADDR_W:0]    word_count;
    logic [DATA_W-1:0]  checksum;
    logic [1:0]         state_dbg;

    prog_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clock      (clock),
        .resetN     (resetN),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_wren   (mem_wren),
        .busy       (busy),
        .loaded     (loaded),
        .overflow   (overflow),
        .word_count (word_count),
        .checksum   (checksum),
        .state_dbg  (state_dbg)
    );

    // Clock / reset
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    int n_cmp = 0;
    int n_err = 0;
    logic [WW-1:0] exp_q[$];

    // Reference model: phase of the load, words taken so far, running sum, last write.
    int                m_phase;   // 0 idle, 1 loading, 2 done, 3 overflowed
    int                m_count;
    logic [DATA_W-1:0] m_sum;
    logic              m_wren;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h, required 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_count = 0;
        m_sum   = '0;
        m_wren  = 1'b0;
        m_addr  = '0;
        m_data  = '0;
        exp_q.delete();
    endtask

    task automatic model_edge();
        m_wren = 1'b0;
        if (m_phase == 1) begin
            if (in_valid) begin
                m_addr = ADDR_W'(m_count % DEPTH);
                m_data = in_data;
                m_wren = 1'b1;
                exp_q.push_back({m_addr, in_data});
                m_count++;
                m_sum = m_sum + in_data;
                if (in_last) m_phase = 2;
                else if (m_count == DEPTH) m_phase = 3;
            end
        end else if (start) begin
            m_phase = 1;
            m_count = 0;
            m_sum   = '0;
        end
    endtask

    // Scoreboard + per-cycle output comparison
    task automatic check_outputs();
        logic [WW-1:0] w;
        check("in_ready",   in_ready,   m_phase == 1);
        check("busy",       busy,       m_phase == 1);
        check("loaded",     loaded,     m_phase == 2);
        check("overflow",   overflow,   m_phase == 3);
        check("word_count", word_count, m_count);
        check("checksum",   checksum,   m_sum);
        check("mem_wren",   mem_wren,   m_wren);
        check("mem_addr",   mem_addr,   m_addr);
        check("mem_data",   mem_data,   m_data);
        if (mem_wren === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_write", 1, 0);
            end else begin
                w = exp_q.pop_front();
                check("write", {mem_addr, mem_data}, w);
            end
        end
    endtask

    // Driver: inputs change 1 time unit after the rising edge, outputs sampled on the falling edge.
    task automatic cycle(input logic v, input logic [DATA_W-1:0] d, input logic l, input logic s);
        in_valid = v;
        in_data  = d;
        in_last  = l;
        start    = s;
        @(negedge clock);
        check_outputs();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic idle_cycle();
        cycle(1'b0, DATA_W'($urandom), 1'b0, 1'b0);
    endtask

    task automatic release_reset();
        in_valid = 1'b0;
        in_last  = 1'b0;
        start    = 1'b0;
        @(negedge clock);
        resetN = 1'b0;
        @(posedge clock);
        model_edge();
        #1;
    endtask

    initial begin
        int len;
        int sent;
        logic v;

        // Power-on reset
        model_reset();
        #3;
        check_outputs();
        check("reset_wc", word_count, 0);
        release_reset();

        // Three-word image, valid held
        cycle(1'b0, '0, 1'b0, 1'b1);
        cycle(1'b1, 16'h1234, 1'b0, 1'b0);
        cycle(1'b1, 16'h0001, 1'b0, 1'b0);
        cycle(1'b1, 16'hFFFF, 1'b1, 1'b0);
        idle_cycle();
        check("t1_loaded", loaded, 1);
        check("t1_count", word_count, 3);
        check("t1_sum", checksum, 16'h1234);
        check("t1_last_addr", mem_addr, 2);

        // Throttled host, one word every third cycle
        cycle(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, DATA_W'($urandom), i == 3, 1'b0);
            cycle(1'b0, DATA_W'($urandom), 1'b0, 1'b0);
            cycle(1'b0, DATA_W'($urandom), 1'b0, 1'b0);
        end
        check("t2_count", word_count, 4);
        check("t2_last_addr", mem_addr, 3);

        // Exactly full image
        cycle(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, DATA_W'($urandom), i == DEPTH-1, 1'b0);
        idle_cycle();
        check("t3_loaded", loaded, 1);
        check("t3_overflow", overflow, 0);
        check("t3_count", word_count, DEPTH);
        check("t3_last_addr", mem_addr, DEPTH-1);

        // Overflow: 33 words offered without in_last
        cycle(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH+1; i++) cycle(1'b1, DATA_W'($urandom), 1'b0, 1'b0);
        idle_cycle();
        check("t4_overflow", overflow, 1);
        check("t4_ready", in_ready, 0);
        check("t4_count", word_count, DEPTH);
        check("t4_last_addr", mem_addr, DEPTH-1);

        // Reset while the fifth word's write pulse is high
        cycle(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b1, DATA_W'($urandom), 1'b0, 1'b0);
        resetN = 1'b1;
        #1;
        model_reset();
        check("t5_wren_async", mem_wren, 0);
        check_outputs();
        release_reset();
        cycle(1'b0, '0, 1'b0, 1'b1);
        cycle(1'b1, 16'h0BEE, 1'b0, 1'b0);
        idle_cycle();
        check("t5_reload_addr", mem_addr, 0);
        cycle(1'b1, 16'h0CAB, 1'b1, 1'b0);
        idle_cycle();

        // Reload straight from DONE
        check("t6_loaded_before", loaded, 1);
        cycle(1'b0, '0, 1'b0, 1'b1);
        check("t6_loaded_dropped", loaded, 0);
        cycle(1'b1, 16'h00AA, 1'b1, 1'b0);
        idle_cycle();
        check("t6_loaded", loaded, 1);
        check("t6_count", word_count, 1);
        check("t6_sum", checksum, 16'h00AA);
        check("t6_addr", mem_addr, 0);

        // Random loads: gaps, ignored start pulses, some overflowing
        for (int ld = 0; ld < 30; ld++) begin
            len  = $urandom_range(1, 36);
            sent = 0;
            cycle(1'b0, '0, 1'b0, 1'b1);
            while (m_phase == 1) begin
                v = ($urandom_range(0, 2) != 0);
                if (v) begin
                    cycle(1'b1, DATA_W'($urandom), sent == len-1, $urandom_range(0, 7) == 0);
                    sent++;
                end else begin
                    cycle(1'b0, DATA_W'($urandom), 1'($urandom), $urandom_range(0, 7) == 0);
                end
            end
            for (int k = 0; k < 3; k++) cycle(1'($urandom), DATA_W'($urandom), 1'($urandom), 1'b0);
        end

        idle_cycle();
        check("pending_writes", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
